// File: rtl/polyunit_loader.sv
// Data-input stage of the polynomial unit: reduces 12-bit coefficients mod Q,
// packs four per RAM word and writes one full polynomial through the RAM write port.
module polyunit_loader #(
    parameter int WID    = 12,
    parameter int DWID   = 48,
    parameter int ADDWID = 6,
    parameter int NCOEF  = 256,
    parameter int Q      = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr,
    input  logic [WID-1:0]    coef_in,
    input  logic              coef_vld,
    output logic              coef_rdy,
    output logic              wren,
    output logic [ADDWID-1:0] wradd,
    output logic [DWID-1:0]   wrdata,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start; coef_rdy low
    // LOAD  | accepting coefficients, writing a word on every lane-3 beat
    // LAST  | final word written this cycle; done pulses
    typedef enum logic [1:0] {IDLE, LOAD, LAST} state_t;

    localparam int CW = $clog2(NCOEF);

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DWID-WID-1:0]   stage;
    logic [WID-1:0]        red;
    logic                  accept;
    logic                  last_beat;
    logic                  lane3;
    logic                  rdy_nxt, busy_nxt, done_nxt, wr_nxt;

    // coef_rdy is a registered copy of (state == LOAD), so it doubles as the accept qualifier
    assign accept    = coef_vld & coef_rdy;
    assign lane3     = (cnt[1:0] == 2'd3);
    assign last_beat = accept && (cnt == CW'(NCOEF - 1));
    assign red       = (coef_in >= WID'(Q)) ? coef_in - WID'(Q) : coef_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (last_beat) state_nxt = LAST;
                LAST:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rdy_nxt  = (state_nxt == LOAD);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == LAST);
        wr_nxt   = accept & ~clr & lane3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_rdy <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wren     <= 1'b0;
            wradd    <= '0;
            wrdata   <= '0;
            cnt      <= '0;
            stage    <= '0;
        end else begin
            coef_rdy <= rdy_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            wren     <= wr_nxt;
            if (clr || (state == IDLE && start)) begin
                cnt   <= '0;
                stage <= '0;
            end else if (accept) begin
                cnt <= cnt + CW'(1);
                case (cnt[1:0])
                    2'd0: stage[WID-1:0]       <= red;
                    2'd1: stage[2*WID-1:WID]   <= red;
                    2'd2: stage[3*WID-1:2*WID] <= red;
                    default: begin
                        wrdata <= {red, stage};
                        wradd  <= ADDWID'(cnt >> 2);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_polyunit_loader.sv
// Directed bench for polyunit_loader: sequential, boundary, backpressure, abort,
// misuse and reset scenarios checked against a reduce-and-pack model.
module tb_polyunit_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, clr, coef_vld;
    logic [11:0] coef_in;
    logic        coef_rdy, wren, busy, done;
    logic [5:0]  wradd;
    logic [47:0] wrdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] coefs [256];
    logic [5:0]  wr_a [$];
    logic [47:0] wr_d [$];
    int          done_cnt = 0;
    int          feed_cycles;

    polyunit_loader dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .coef_in(coef_in), .coef_vld(coef_vld), .coef_rdy(coef_rdy),
        .wren(wren), .wradd(wradd), .wrdata(wrdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wren) begin
            wr_a.push_back(wradd);
            wr_d.push_back(wrdata);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] exp_word(input int w);
        logic [47:0] word;
        logic [11:0] c;
        word = '0;
        for (int l = 0; l < 4; l++) begin
            c = coefs[4*w + l];
            word[12*l +: 12] = (c >= 12'd3329) ? c - 12'd3329 : c;
        end
        return word;
    endfunction

    task automatic clear_log();
        @(posedge clk);
        #1;
        wr_a.delete();
        wr_d.delete();
        done_cnt = 0;
    endtask

    // Drives coefs[] until n_acc beats are accepted; optional start on the first cycle
    // and an illegal start pulse mid-load.
    task automatic feed(input int n_acc, input int gap_pct, input bit do_start, input bit poke);
        int  idx;
        bit  acc;
        idx = 0;
        feed_cycles = 0;
        while (idx < n_acc && feed_cycles < 5000) begin
            @(negedge clk);
            coef_vld = ($urandom_range(99) >= gap_pct);
            coef_in  = coefs[idx];
            start    = (do_start && feed_cycles == 0) || (poke && idx == 5);
            acc      = coef_vld && coef_rdy;
            @(posedge clk);
            if (acc) idx++;
            feed_cycles++;
        end
        chk("feed_accepted", idx, n_acc);
        #1;
        coef_vld = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_words(input string tag, input int n);
        chk({tag, "_nwrites"}, wr_a.size(), n);
        for (int i = 0; i < n && i < wr_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_a[i], i);
            chk($sformatf("%s_data%0d", tag, i), wr_d[i], exp_word(i));
        end
    endtask

    task automatic seq_coefs();
        for (int i = 0; i < 256; i++) coefs[i] = 12'(i);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; clr = 1'b0; coef_vld = 1'b0; coef_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coef_rdy", coef_rdy, 0);
        chk("rst_wren", wren, 0);
        chk("rst_wradd", wradd, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst = 1'b1;

        // Sequential load with vld held high
        seq_coefs();
        clear_log();
        feed(256, 0, 1'b1, 1'b0);
        chk("seq_cycles", feed_cycles, 257);
        chk("seq_done_last", done, 1);
        chk("seq_wren_last", wren, 1);
        chk("seq_wradd_last", wradd, 63);
        idle(3);
        check_words("seq", 64);
        if (wr_d.size() == 64) begin
            chk("seq_word0", wr_d[0], 48'h003002001000);
            chk("seq_word63", wr_d[63], 48'h0FF0FE0FD0FC);
        end
        chk("seq_done_cnt", done_cnt, 1);
        chk("seq_rdy_after", coef_rdy, 0);
        chk("seq_busy_after", busy, 0);

        // Reduction boundaries in word 0
        coefs[0] = 12'd3328; coefs[1] = 12'd3329; coefs[2] = 12'd4095; coefs[3] = 12'd0;
        clear_log();
        feed(256, 0, 1'b1, 1'b0);
        idle(3);
        if (wr_d.size() > 0) chk("red_word0", wr_d[0], 48'h0002FE000D00);
        check_words("red", 64);

        // Backpressure
        seq_coefs();
        clear_log();
        feed(256, 50, 1'b1, 1'b0);
        idle(3);
        check_words("bp", 64);
        chk("bp_done_cnt", done_cnt, 1);

        // Abort after 10 coefficients
        clear_log();
        feed(10, 0, 1'b1, 1'b0);
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_rdy", coef_rdy, 0);
        chk("clr_busy", busy, 0);
        idle(5);
        check_words("clr", 2);
        chk("clr_done_cnt", done_cnt, 0);
        clear_log();
        feed(256, 0, 1'b1, 1'b0);
        idle(3);
        check_words("clr_restart", 64);
        chk("clr_restart_done", done_cnt, 1);

        // Misuse: vld in IDLE, start during LOAD
        for (int i = 0; i < 256; i++) coefs[i] = 12'($urandom_range(4095));
        clear_log();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            coef_vld = 1'b1;
            coef_in  = 12'($urandom_range(4095));
        end
        @(negedge clk) coef_vld = 1'b0;
        idle(2);
        chk("mis_idle_writes", wr_a.size(), 0);
        chk("mis_idle_rdy", coef_rdy, 0);
        feed(256, 20, 1'b1, 1'b1);
        idle(3);
        check_words("mis", 64);
        chk("mis_done_cnt", done_cnt, 1);

        // Async reset after 100 coefficients
        seq_coefs();
        clear_log();
        feed(100, 0, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_coef_rdy", coef_rdy, 0);
        chk("arst_wren", wren, 0);
        chk("arst_wradd", wradd, 0);
        chk("arst_wrdata", wrdata, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk) rst = 1'b1;
        idle(5);
        chk("arst_nwrites", wr_a.size(), 25);
        chk("arst_done_cnt", done_cnt, 0);
        clear_log();
        feed(256, 0, 1'b1, 1'b0);
        idle(3);
        check_words("arst_reload", 64);
        chk("arst_reload_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/polyunit_loader.md
# polyunit_loader

Upstream data-input stage for the polynomial unit. It accepts a stream of 12-bit Kyber coefficients over a valid/ready handshake and reduces each one once modulo q = 3329. It packs four coefficients into each 48-bit RAM word and drives the write port of the polynomial RAM (`wren`/`wradd`/`wrdata`) for one full polynomial. The polyunit controller starts it in its data-in mode and waits for `done` before starting NTT/INTT.

## Interface
Parameters:
- `WID`, 12, coefficient width
- `DWID`, 48, RAM word width (`4*WID`)
- `ADDWID`, 6, RAM address width
- `NCOEF`, 256, coefficients per polynomial (multiple of 4, at most `4*2^ADDWID`)
- `Q`, 3329, modulus

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin loading a polynomial; honoured only in IDLE
- `clr`  in  1  synchronous abort; returns to IDLE, no `done`
- `coef_in`  in  WID  input coefficient, 0..4095
- `coef_vld`  in  1  `coef_in` valid
- `coef_rdy`  out  1  loader accepts `coef_in` this cycle
- `wren`  out  1  RAM write enable
- `wradd`  out  ADDWID  RAM write address
- `wrdata`  out  DWID  RAM write data
- `busy`  out  1  high in LOAD and LAST
- `done`  out  1  one-cycle pulse when the final word is written

## Operation
- FSM states: IDLE, LOAD, LAST.
  - IDLE -> LOAD on `start & ~clr`.
  - LOAD -> LAST on acceptance of coefficient `NCOEF-1`.
  - LAST -> IDLE unconditionally.
  - Any state -> IDLE on `clr`; `clr` has priority over every other transition.
- `coef_rdy` = (state == LOAD), driven from a register. A beat is accepted when `coef_vld & coef_rdy` at a rising edge.
- Reduction per beat: r = (c >= Q) ? c - Q : c. Output is `WID` bits and always < Q.
- Coefficient counter `cnt` has log2(NCOEF) bits and is cleared on IDLE -> LOAD.
  - lane = `cnt[1:0]`; word = `cnt[..:2]`.
  - r is placed in `wrdata` bits [WID*lane+WID-1 : WID*lane], so coefficient 0 sits in the LSBs.
- On accepting lane 3, the assembled word is registered to `wrdata`, `wradd` = word, and `wren` = 1 for exactly the next cycle.
- `wren` = 0 in every other cycle. Lanes 0..2 are held in a staging register and never written partially.
- `done` is high in the LAST cycle, coincident with the final `wren` (`wradd` = NCOEF/4-1).
- `start` outside IDLE is ignored. `coef_vld` outside LOAD is ignored and nothing is consumed.
- `clr` mid-load:
  - discards staged lanes and `cnt`;
  - words already written stay in RAM;
  - no further `wren`; `done` is never pulsed.
  - A `clr` coinciding with a lane-3 acceptance suppresses that write.
- Reset (`rst` = 0, asynchronous) forces:
  - state IDLE, `cnt` = 0;
  - `coef_rdy` = 0, `wren` = 0, `wradd` = 0, `wrdata` = 0, `busy` = 0, `done` = 0;
  - staging register cleared.
- Reset mid-operation leaves the RAM untouched and produces no `done`.

## Timing
- Latency: accepted lane-3 beat at edge t -> `wren` high in cycle t..t+1 (one cycle after the edge).
- `start` sampled at edge t -> `coef_rdy` high from just after t. The earliest beat is accepted at edge t+1.
- With `coef_vld` held high, one coefficient is accepted per cycle and a write occurs every 4th cycle.
  - Full polynomial: NCOEF acceptance edges, then LAST, so `done` arrives NCOEF+1 cycles after `start`.
- Gaps in `coef_vld` stall `cnt` and the staging register. `wren` fires only on lane-3 acceptances.
- `coef_rdy` drops in LAST (after acceptance of coefficient NCOEF-1) and stays low until the next `start`.
- Back-to-back polynomials: `start` may be asserted in the cycle after LAST (IDLE). The minimum turnaround is 1 idle cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Sequential load: `start`, then coef = 0..255 with `coef_vld` held high.
  - 64 writes; word 0 = 0x003002001000 at `wradd` 0; word 63 = 0x0FF0FE0FD0FC at `wradd` 63.
  - `done` coincides with the last `wren`, 257 cycles after `start`.
- Reduction boundaries: coef 3328, 3329, 4095, 0 in one word -> `wrdata` = 0x000 2FE 000 D00 (lanes 3..0 = 0, 766, 0, 3328) = 0x0002FE000D00.
- Backpressure: random `coef_vld` gaps (~50%) with the same data as the sequential load.
  - Identical 64 words and addresses; `wren` only on lane-3 acceptances; `done` exactly once.
- Abort: `clr` after 10 accepted coefficients.
  - Writes seen at `wradd` 0,1 only; `coef_rdy` = 0 next cycle; no `done`.
  - A following `start` plus full load restarts from `wradd` 0.
- Protocol misuse: `start` pulsed during LOAD, and `coef_vld` high during IDLE -> no effect on `cnt`, addresses or data.
- Reset: `rst` low for 1 cycle mid-load (after 100 coefficients).
  - All outputs 0 immediately (asynchronous); no further `wren`; no `done`.
  - Next `start` loads normally.
